// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the latency-modelled data-memory responder.
package dm_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BITS = 32;
  localparam int BE_BITS   = WORD_BITS / 8;
  localparam logic [BE_BITS-1:0] BE_FULL = 4'b1111;

  // True when any byte-address bit above the word-index field is set.
  function automatic logic addr_oob(input logic [31:0] addr, input int unsigned idx_msb);
    return (addr >> (idx_msb + 1)) != 32'd0;
  endfunction

endpackage

// File: rtl/dm_responder_if.sv
// Request/response bundle between the MEM-stage initiator and the responder.
interface dm_responder_if;
  import dm_resp_pkg::*;

  logic                 req;
  logic                 we;
  logic [BE_BITS-1:0]   be;
  logic [31:0]          addr;
  logic [WORD_BITS-1:0] wdata;
  logic                 ready;
  logic                 rvalid;
  logic [WORD_BITS-1:0] rdata;
  logic                 err;

  modport master (
    output req, we, be, addr, wdata,
    input  ready, rvalid, rdata, err
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output ready, rvalid, rdata, err
  );

endinterface

// File: rtl/dm_array.sv
// Word array stored as one byte-wide bank per lane: byte-enabled write,
// asynchronous read, and a full clear while reset is held.
module dm_array
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        waddr,
  input  logic [BE_BITS-1:0]   wbe,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [AW-1:0]        raddr,
  output logic [WORD_BITS-1:0] rdata
);

  generate
    for (genvar gi = 0; gi < BE_BITS; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH_WORDS];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int w = 0; w < DEPTH_WORDS; w++) begin
            lane_mem[w] <= 8'h00;
          end
        end else if (wr_en && wbe[gi]) begin
          lane_mem[waddr] <= wdata[8*gi +: 8];
        end
      end

      assign rdata[8*gi +: 8] = lane_mem[raddr];
    end
  endgenerate

endmodule

// File: rtl/dm_responder.sv
// Single-outstanding data-memory responder with a fixed accept-to-response
// latency; commits the write or samples the read on the edge entering RESP.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic           clk,
  input  logic           reset,
  dm_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t               state_reg;
  logic [3:0]           cnt_reg;
  logic                 ready_reg;
  logic                 rvalid_reg;
  logic [WORD_BITS-1:0] rdata_reg;
  logic                 err_reg;

  logic                 cap_we_reg;
  logic [BE_BITS-1:0]   cap_be_reg;
  logic [31:0]          cap_addr_reg;
  logic [WORD_BITS-1:0] cap_wdata_reg;

  logic                 accept;
  logic                 cur_we;
  logic [BE_BITS-1:0]   cur_be;
  logic [31:0]          cur_addr;
  logic [WORD_BITS-1:0] cur_wdata;
  logic                 cur_oob;
  logic                 enter_resp;
  logic                 arr_wr_en;
  logic [WORD_BITS-1:0] arr_rdata;
  logic [WORD_BITS-1:0] resp_rdata;

  assign accept = bus.req && ready_reg;

  // With LATENCY=1 the commit edge is the accept edge, so the live bus
  // payload is used before it lands in the capture registers.
  always_comb begin
    cur_we    = cap_we_reg;
    cur_be    = cap_be_reg;
    cur_addr  = cap_addr_reg;
    cur_wdata = cap_wdata_reg;
    if (state_reg == IDLE) begin
      cur_we    = bus.we;
      cur_be    = bus.be;
      cur_addr  = bus.addr;
      cur_wdata = bus.wdata;
    end
  end

  assign cur_oob    = addr_oob(cur_addr, AW + 1);
  assign enter_resp = ((state_reg == IDLE) && accept && (LATENCY == 1)) ||
                      ((state_reg == WAIT) && (cnt_reg == 4'd0));
  assign arr_wr_en  = enter_resp && cur_we && !cur_oob && !reset;
  assign resp_rdata = (cur_we || cur_oob) ? '0 : arr_rdata;

  dm_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .wr_en (arr_wr_en),
    .waddr (cur_addr[AW+1:2]),
    .wbe   (cur_be),
    .wdata (cur_wdata),
    .raddr (cur_addr[AW+1:2]),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      ready_reg     <= 1'b1;
      rvalid_reg    <= 1'b0;
      rdata_reg     <= '0;
      err_reg       <= 1'b0;
      cap_we_reg    <= 1'b0;
      cap_be_reg    <= '0;
      cap_addr_reg  <= '0;
      cap_wdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            cap_we_reg    <= bus.we;
            cap_be_reg    <= bus.be;
            cap_addr_reg  <= bus.addr;
            cap_wdata_reg <= bus.wdata;
            ready_reg     <= 1'b0;
            if (LATENCY == 1) begin
              state_reg  <= RESP;
              rvalid_reg <= 1'b1;
              rdata_reg  <= resp_rdata;
              err_reg    <= cur_oob;
            end else begin
              state_reg <= WAIT;
              cnt_reg   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt_reg == 4'd0) begin
            state_reg  <= RESP;
            rvalid_reg <= 1'b1;
            rdata_reg  <= resp_rdata;
            err_reg    <= cur_oob;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg  <= IDLE;
          ready_reg  <= 1'b1;
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
          err_reg    <= 1'b0;
        end
        default: begin
          state_reg  <= IDLE;
          ready_reg  <= 1'b1;
          rvalid_reg <= 1'b0;
          rdata_reg  <= '0;
          err_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_reg;
  assign bus.rvalid = rvalid_reg;
  assign bus.rdata  = rdata_reg;
  assign bus.err    = err_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench: one responder with LATENCY=2 and one with LATENCY=1,
// directed transactions with hand-computed expected responses.
module tb_dm_responder;
  import dm_resp_pkg::*;

  localparam int LAT_A = 2;
  localparam int LAT_B = 1;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_responder_if bus_a();
  dm_responder_if bus_b();

  dm_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  dm_responder #(.DEPTH_WORDS(4096), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: rvalid is sampled by edge cyc+1, so latency = cyc+1-accept.
  initial begin : mon_a
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_a.rvalid === 1'b1) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = q_a.pop_front();
          chk("a_rdata", bus_a.rdata, e.rdata);
          chk("a_err", {31'd0, bus_a.err}, {31'd0, e.err});
          chk("a_latency", 32'(cyc + 1 - e.acc), 32'(LAT_A));
          $display("A resp: rdata=%h err=%0b accept=%0d", bus_a.rdata, bus_a.err, e.acc);
        end
      end else if (prev_rv) begin
        chk("a_rdata_clear", bus_a.rdata, 32'd0);
        chk("a_err_clear", {31'd0, bus_a.err}, 32'd0);
      end
      prev_rv = bus_a.rvalid;
    end
  end

  initial begin : mon_b
    logic prev_rv;
    exp_t e;
    prev_rv = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_b.rvalid === 1'b1) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_rvalid", 32'd1, 32'd0);
        end else begin
          e = q_b.pop_front();
          chk("b_rdata", bus_b.rdata, e.rdata);
          chk("b_err", {31'd0, bus_b.err}, {31'd0, e.err});
          chk("b_latency", 32'(cyc + 1 - e.acc), 32'(LAT_B));
          $display("B resp: rdata=%h err=%0b accept=%0d", bus_b.rdata, bus_b.err, e.acc);
        end
      end else if (prev_rv) begin
        chk("b_rdata_clear", bus_b.rdata, 32'd0);
        chk("b_err_clear", {31'd0, bus_b.err}, 32'd0);
      end
      prev_rv = bus_b.rvalid;
    end
  end

  task automatic drive(input int which, input logic rq, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd);
    if (which == 0) begin
      bus_a.req = rq; bus_a.we = w; bus_a.be = b; bus_a.addr = a; bus_a.wdata = wd;
    end else begin
      bus_b.req = rq; bus_b.we = w; bus_b.be = b; bus_b.addr = a; bus_b.wdata = wd;
    end
  endtask

  // Called on a negedge; raises req, waits for ready, returns on the negedge
  // after the accept edge with req still asserted.
  task automatic issue(input int which, input logic w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err,
                       input bit push, output int acc);
    int   n;
    logic rdy;
    exp_t e;
    drive(which, 1'b1, w, b, a, wd);
    n = 0;
    acc = -1;
    forever begin
      rdy = (which == 0) ? bus_a.ready : bus_b.ready;
      if (rdy === 1'b1) break;
      if (n > 50) begin
        chk("ready_timeout", 32'd0, 32'd1);
        drive(which, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        return;
      end
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (push) begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      e.acc   = acc;
      if (which == 0) q_a.push_back(e);
      else            q_b.push_back(e);
    end
    $display("%s issue: we=%0b be=%h addr=%h wdata=%h accept=%0d",
             (which == 0) ? "A" : "B", w, b, a, wd, acc);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t1, t2, t3;
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    chk("a_reset_ready", {31'd0, bus_a.ready}, 32'd1);
    chk("a_reset_rvalid", {31'd0, bus_a.rvalid}, 32'd0);
    chk("a_reset_rdata", bus_a.rdata, 32'd0);
    chk("a_reset_err", {31'd0, bus_a.err}, 32'd0);
    chk("b_reset_ready", {31'd0, bus_b.ready}, 32'd1);
    chk("b_reset_rvalid", {31'd0, bus_b.rvalid}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Full-word write, then read back.
    issue(0, 1'b1, BE_FULL, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_5678, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Single-lane write merges into the existing word.
    issue(0, 1'b1, 4'b0010, 32'h0000_0010, 32'h0000_AB00, 32'h0, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_AB78, 1'b0, 1'b1, t1);

    // req held continuously across three reads; payload changes during WAIT.
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_AB78, 1'b0, 1'b1, t1);
    issue(0, 1'b0, 4'h0, 32'h0000_0014, 32'h0, 32'h0000_0000, 1'b0, 1'b1, t2);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_AB78, 1'b0, 1'b1, t3);
    drive(0, 1'b0, 1'b1, BE_FULL, 32'h0000_0010, 32'hDEAD_BEEF);
    chk("a_ready_in_wait", {31'd0, bus_a.ready}, 32'd0);
    @(negedge clk);
    chk("a_ready_in_resp", {31'd0, bus_a.ready}, 32'd0);
    chk("a_spacing_1_2", 32'(t2 - t1), 32'd3);
    chk("a_spacing_2_3", 32'(t3 - t2), 32'd3);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h1234_AB78, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Out-of-range read and write, then word 0 is still clear.
    issue(0, 1'b0, 4'h0, 32'h0001_0000, 32'h0, 32'h0, 1'b1, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b1, BE_FULL, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h0000_0000, 32'h0, 32'h0, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // Reset during WAIT aborts the write; no response is expected.
    issue(0, 1'b1, BE_FULL, 32'h0000_0020, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, t1);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    chk("a_ready_after_abort", {31'd0, bus_a.ready}, 32'd1);
    chk("a_rvalid_after_abort", {31'd0, bus_a.rvalid}, 32'd0);
    repeat (2) @(negedge clk);
    issue(0, 1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    issue(0, 1'b0, 4'h0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b1, t1);
    drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);

    // LATENCY=1 instance: write then read with req held.
    issue(1, 1'b1, BE_FULL, 32'h0000_0004, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b1, t1);
    issue(1, 1'b0, 4'h0, 32'h0000_0004, 32'h0, 32'hCAFE_F00D, 1'b0, 1'b1, t2);
    drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("b_spacing", 32'(t2 - t1), 32'd2);

    repeat (6) @(negedge clk);
    chk("a_queue_drained", 32'(q_a.size()), 32'd0);
    chk("b_queue_drained", 32'(q_b.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
